smpl_seq_queue: RTL
===================

Name: smpl_seq_queue

Overview:
- Circular sample queue that supplies stereo audio samples to the FIR band filters, which are consumers of `sequencing`, `lft_in` and `rght_in`.
- Stores incoming left/right 16-bit samples in a ring buffer.
- After each newly written sample, once at least TAPS samples are held, replays the most recent TAPS samples oldest-to-newest, one per clock, with `sequencing` asserted.
- Sits between the codec sample interface and all filter instances, which share its outputs.

Parameters:
- DEPTH, 1536, ring buffer entries per channel; must be >= TAPS+2.
- TAPS, 1021, samples replayed per sequence; equals filter tap count.
- AW, 11, pointer width; 2**AW >= DEPTH.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- wrt_smpl  input  1  one-cycle strobe; lft_smpl/rght_smpl valid
- lft_smpl  input  16  signed left sample to store
- rght_smpl  input  16  signed right sample to store
- lft_out  output  16  signed left sample being replayed
- rght_out  output  16  signed right sample being replayed
- sequencing  output  1  high for exactly TAPS consecutive cycles per replay
- overrun  output  1  one-cycle pulse when a write-triggered replay is lost

Behaviour:
- One clock domain, clk. rst_n is asynchronous and active-low.
- Reset values:
  - sequencing=0, overrun=0, lft_out=0, rght_out=0.
  - write pointer=0, fill count=0, pending=0, state=IDLE.
  - Memory contents are not reset.
- Reset mid-sequence aborts immediately; the fill count restarts from 0.
- Write path:
  - On a clk edge with wrt_smpl=1, store both samples at new_ptr.
  - new_ptr increments and wraps from DEPTH-1 to 0.
  - fill count increments and saturates at TAPS.
  - Writes are accepted in every state; none are ever dropped.
- Trigger: a write whose post-write fill count is TAPS is a trigger.
- Window:
  - Captured when a sequence starts.
  - oldest = (new_ptr - TAPS) mod DEPTH, using new_ptr after the triggering write; newest = the triggering sample.
- FSM states: IDLE, GAP, SEQ.
  - IDLE: trigger at edge T → SEQ.
  - SEQ:
    - sequencing=1 during cycles T+1 .. T+TAPS.
    - During cycle T+1+k (k=0..TAPS-1), lft_out/rght_out = sample at (oldest+k) mod DEPTH; read addresses wrap at DEPTH.
    - After the last output → GAP.
  - GAP: exactly one cycle with sequencing=0, so filters see a fresh rising edge. Then:
    - if pending=1, go to SEQ and clear pending; the window is recaptured from the current new_ptr;
    - otherwise go to IDLE.
- Trigger while in SEQ or GAP:
  - sets pending;
  - if pending is already 1, pulse overrun for one cycle instead; the trigger is lost and pending stays 1.
- A trigger in the same cycle that a sequence ends is handled per GAP.
- No read/write hazard: DEPTH >= TAPS+2 keeps in-flight writes outside the window being replayed.
- Outputs:
  - registered;
  - hold their last value while sequencing=0;
  - no combinational path from wrt_smpl to any output.
- Memory: inferable as two simple dual-port synchronous RAMs (or one 32-bit wide), one write port and one registered read port. Read address leads the output by one cycle.

Test Plan (TAPS=8, DEPTH=12 for directed runs; one regression at defaults):
- Reset then 7 writes (samples 1..7) → sequencing stays 0; outputs stay 0. 8th write (8) at edge T → sequencing high cycles T+1..T+8; lft_out = 1,2,...,8; rght_out = -1..-8 when written as negatives.
- 10 more writes spaced 20 cycles apart → each write starts a replay of its last 8 samples, e.g. after sample 14 the replay is 7..14. Covers read wrap past index 11 and write wrap to 0.
- Write during an active replay → replay unchanged; one GAP cycle with sequencing=0; second replay of the window ending at the new sample; overrun stays 0.
- Two writes during one replay → second write pulses overrun one cycle; one pending replay ends at the newest sample.
- Assert rst_n=0 mid-replay → sequencing=0 and outputs=0 immediately (asynchronous). After release, 7 writes produce no replay; the 8th does.
- Defaults with 48 kHz strobes at 50 MHz (1041-cycle spacing) → every write yields 1021 sequencing cycles plus a gap; overrun never asserts.

Source files
------------

// File: rtl/smpl_seq_queue.sv
// -----------------------------------------------------------------------------
// smpl_seq_queue
//
// Circular stereo sample queue feeding the FIR band filters. Each incoming
// left/right sample pair is stored in a ring buffer. Once TAPS samples have
// been written since reset, every new write replays the most recent TAPS
// samples, oldest first, one per clock, with `sequencing` high for exactly
// TAPS cycles. Consecutive replays are always separated by at least one
// cycle with `sequencing` low, so every filter sees a fresh rising edge.
//
// A write that arrives while a replay is running (or during the one-cycle
// gap after it) is remembered as pending and replayed after the gap. A second
// such write while one is already pending is lost and reported on `overrun`.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   wrt_smpl    one-cycle strobe, lft_smpl/rght_smpl valid
//   lft_smpl    signed 16-bit left sample to store
//   rght_smpl   signed 16-bit right sample to store
//   lft_out     signed 16-bit left sample being replayed (registered)
//   rght_out    signed 16-bit right sample being replayed (registered)
//   sequencing  high for TAPS consecutive cycles per replay (registered)
//   overrun     one-cycle pulse when a triggered replay is dropped (registered)
// -----------------------------------------------------------------------------
module smpl_seq_queue #(
   parameter int DEPTH = 1536,
   parameter int TAPS  = 1021,
   parameter int AW    = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wrt_smpl,
   input  logic signed [15:0] lft_smpl,
   input  logic signed [15:0] rght_smpl,
   output logic signed [15:0] lft_out,
   output logic signed [15:0] rght_out,
   output logic               sequencing,
   output logic               overrun
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GAP  = 2'd1,
      ST_SEQ  = 2'd2
   } state_e;

   // One extra bit on the modular arithmetic so sums never overflow.
   localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   TAPS_X   = (AW+1)'(TAPS);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] TAPS_A   = AW'(TAPS);
   localparam logic [AW-1:0] TAPS_M1  = AW'(TAPS - 1);
   localparam logic [AW-1:0] ZERO_A   = {AW{1'b0}};
   localparam logic [AW-1:0] ONE_A    = {{(AW-1){1'b0}}, 1'b1};

   // Ring pointer advance, wrapping from DEPTH-1 back to 0.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      logic [AW-1:0] r;
      if (p == LAST_PTR) begin
         r = ZERO_A;
      end else begin
         r = p + ONE_A;
      end
      return r;
   endfunction

   // Oldest entry of the window whose newest entry sits just below p.
   function automatic logic [AW-1:0] win_start(input logic [AW-1:0] p);
      logic [AW:0] px;
      logic [AW:0] r;
      px = {1'b0, p};
      if (px >= TAPS_X) begin
         r = px - TAPS_X;
      end else begin
         r = px + DEPTH_X - TAPS_X;
      end
      return r[AW-1:0];
   endfunction

   // Window base plus replay offset, wrapping at DEPTH.
   function automatic logic [AW-1:0] addr_add(input logic [AW-1:0] b,
                                              input logic [AW-1:0] k);
      logic [AW:0] s;
      logic [AW:0] r;
      s = {1'b0, b} + {1'b0, k};
      if (s >= DEPTH_X) begin
         r = s - DEPTH_X;
      end else begin
         r = s;
      end
      return r[AW-1:0];
   endfunction

   // Sample storage (no reset on the arrays)
   logic signed [15:0] mem_l_q [0:DEPTH-1];
   logic signed [15:0] mem_r_q [0:DEPTH-1];

   // Control state
   state_e        state_q,   state_d;
   logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
   logic [AW-1:0] fill_q,    fill_d;
   logic          pending_q, pending_d;
   logic [AW-1:0] base_q,    base_d;
   logic [AW-1:0] idx_q,     idx_d;
   logic          seq_q,     seq_d;
   logic          ovr_q,     ovr_d;

   // Registered read port doubles as the output register
   logic signed [15:0] lft_q;
   logic signed [15:0] rght_q;

   logic          trig_s;
   logic          start_s;
   logic [AW-1:0] start_base_s;
   logic          rd_en_s;
   logic [AW-1:0] rd_addr_s;

   // A write that brings the fill count to TAPS (or finds it saturated) triggers.
   assign trig_s = wrt_smpl & (fill_q >= TAPS_M1);

   // Write pointer and saturating fill count next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      if (wrt_smpl) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
         if (fill_q == TAPS_A) begin
            fill_d = fill_q;
         end else begin
            fill_d = fill_q + ONE_A;
         end
      end else begin
         wr_ptr_d = wr_ptr_q;
         fill_d   = fill_q;
      end
   end

   // Replay FSM next-state, read request and output control.
   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      base_d       = base_q;
      idx_d        = idx_q;
      seq_d        = seq_q;
      ovr_d        = 1'b0;
      start_s      = 1'b0;
      start_base_s = base_q;
      rd_en_s      = 1'b0;
      rd_addr_s    = base_q;

      case (state_q)
         ST_IDLE: begin
            if (trig_s) begin
               // Window ends at the sample being written on this edge.
               start_s      = 1'b1;
               start_base_s = win_start(wr_ptr_d);
            end else begin
               seq_d = 1'b0;
            end
         end

         ST_SEQ: begin
            if (trig_s) begin
               if (pending_q) begin
                  ovr_d = 1'b1;
               end else begin
                  pending_d = 1'b1;
               end
            end else begin
               pending_d = pending_q;
            end

            if (idx_q == TAPS_A) begin
               state_d = ST_GAP;
               seq_d   = 1'b0;
            end else begin
               rd_en_s   = 1'b1;
               rd_addr_s = addr_add(base_q, idx_q);
               idx_d     = idx_q + ONE_A;
               seq_d     = 1'b1;
            end
         end

         ST_GAP: begin
            if (pending_q) begin
               // Pending replay covers everything written before this edge;
               // a write on this very edge becomes the next pending replay.
               start_s      = 1'b1;
               start_base_s = win_start(wr_ptr_q);
               pending_d    = trig_s;
            end else if (trig_s) begin
               start_s      = 1'b1;
               start_base_s = win_start(wr_ptr_d);
            end else begin
               state_d = ST_IDLE;
               seq_d   = 1'b0;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            pending_d = 1'b0;
            seq_d     = 1'b0;
         end
      endcase

      // Sequence launch: read the oldest entry now, offset 1 next cycle.
      if (start_s) begin
         state_d   = ST_SEQ;
         base_d    = start_base_s;
         rd_en_s   = 1'b1;
         rd_addr_s = start_base_s;
         idx_d     = ONE_A;
         seq_d     = 1'b1;
      end else begin
         base_d = base_d;
      end
   end

   // Control and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= ZERO_A;
         fill_q    <= ZERO_A;
         pending_q <= 1'b0;
         base_q    <= ZERO_A;
         idx_q     <= ZERO_A;
         seq_q     <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         fill_q    <= fill_d;
         pending_q <= pending_d;
         base_q    <= base_d;
         idx_q     <= idx_d;
         seq_q     <= seq_d;
         ovr_q     <= ovr_d;
      end
   end

   // Sample RAM write port.
   always_ff @(posedge clk) begin
      if (wrt_smpl) begin
         mem_l_q[wr_ptr_q] <= lft_smpl;
         mem_r_q[wr_ptr_q] <= rght_smpl;
      end
   end

   // Sample RAM registered read port; holds its value between replays.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_q  <= 16'sd0;
         rght_q <= 16'sd0;
      end else if (rd_en_s) begin
         lft_q  <= mem_l_q[rd_addr_s];
         rght_q <= mem_r_q[rd_addr_s];
      end else begin
         lft_q  <= lft_q;
         rght_q <= rght_q;
      end
   end

   assign lft_out    = lft_q;
   assign rght_out   = rght_q;
   assign sequencing = seq_q;
   assign overrun    = ovr_q;

endmodule
